keyb_decoder: RTL and testbench

Downstream stage of the 4x4 keypad scan controller. Consumes the per-scan `btn_pressed`/`btn_code` pair, debounces it, decodes the one-hot column/row code into a 4-bit key index, and emits one event per new press. Events are queued in a small FIFO behind a valid/ready handshake for the application logic.

---
 rtl/keyb_decoder.sv | 176 +++++++++++++++++
 tb/tb_keyb_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyb_decoder.sv
// keyb_decoder: debounces the keypad scan controller's {btn_pressed, btn_code}
// pair, decodes the one-hot column/row code into a 4-bit key index and queues
// one event per new press in a small FIFO behind a valid/ready handshake.
module keyb_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_pressed,
  input  logic [7:0]                    btn_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [3:0]                    key_code,
  output logic [$clog2(FIFO_DEPTH):0]   key_count,
  output logic                          overflow,
  output logic                          multi_key
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HELD, LOCKED} state_t;
  typedef enum logic [1:0] {CLS_RELEASED, CLS_VALID, CLS_INVALID} class_t;

  // Exactly one bit set in a nibble.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Bit position of a one-hot nibble (only meaningful when one-hot).
  function automatic logic [1:0] idx4(input logic [3:0] v);
    logic [1:0] i;
    case (v)
      4'b0010: i = 2'd1;
      4'b0100: i = 2'd2;
      4'b1000: i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  logic [8:0]    in_d;
  logic [8:0]    in_q;
  logic [CW-1:0] cnt;
  logic          stable;
  class_t        cls;
  logic [3:0]    dec_code;

  state_t        state, state_nxt;
  logic          push;
  logic          multi_set;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;

  assign in_d     = {btn_pressed, btn_code};
  // in_d equals in_q whenever stable fires, so classify the live input.
  assign stable   = (in_d == in_q) && (cnt == CNT_LAST);
  assign dec_code = {idx4(in_d[3:0]), idx4(in_d[7:4])};

  // Classify the sampled input as released, a single key, or an invalid chord.
  always_comb begin
    if (!in_d[8])
      cls = CLS_RELEASED;
    else if (is_onehot4(in_d[7:4]) && is_onehot4(in_d[3:0]))
      cls = CLS_VALID;
    else
      cls = CLS_INVALID;
  end

  // Sample register and stability counter; the count saturates so the
  // stable strobe fires once per settled input value.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q <= 9'h000;
      cnt  <= '0;
    end else begin
      in_q <= in_d;
      if (in_d != in_q)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Press-tracking state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: acts only on the stable strobe.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    multi_set = 1'b0;
    if (stable) begin
      case (state)
        IDLE: begin
          if (cls == CLS_VALID) begin
            push      = 1'b1;
            state_nxt = HELD;
          end else if (cls == CLS_INVALID) begin
            multi_set = 1'b1;
            state_nxt = LOCKED;
          end
        end
        HELD: begin
          if (cls == CLS_RELEASED) begin
            state_nxt = IDLE;
          end else if (cls == CLS_VALID) begin
            push      = 1'b1;
          end else begin
            multi_set = 1'b1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (cls == CLS_RELEASED) begin
            state_nxt = IDLE;
          end else if (cls == CLS_VALID) begin
            push      = 1'b1;
            state_nxt = HELD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FIFO control: a pop frees the slot a same-cycle push needs when full.
  assign key_valid = (key_count != '0);
  assign full      = (key_count == CNT_FULL);
  assign pop       = key_valid && key_ready;
  assign wr_en     = push && (!full || pop);
  assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;

  // Event storage.
  // NOTE: the storage array is not reset; key_code is gated by key_valid, so
  // stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dec_code;
  end

  // Pointers, occupancy and the one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      key_count <= '0;
      overflow  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   key_count <= key_count + 1'b1;
        2'b01:   key_count <= key_count - 1'b1;
        default: key_count <= key_count;
      endcase
      overflow  <= push && full && !pop;
      multi_key <= multi_set;
    end
  end

endmodule

// File: tb/tb_keyb_decoder.sv
// Self-checking bench for keyb_decoder: a table of press/release vectors plus
// hand-written sequences for debounce timing, FIFO full/overflow and reset.
// Expected key indices go into a scoreboard queue when a press is driven and
// are compared whenever the DUT hands an event to the consumer.
module tb_keyb_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_pressed;
  logic [7:0] btn_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic [2:0] key_count;
  logic       overflow;
  logic       multi_key;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int pop_events = 0;
  int ovf_cycles = 0;
  int multi_cycles = 0;

  typedef struct {
    logic       pressed;
    logic [7:0] code;
    int         hold;
    int         exp_events;
    int         exp_key;
    int         exp_multi;
  } vec_t;

  vec_t vecs[10];

  keyb_decoder #(.DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pressed(btn_pressed),
    .btn_code   (btn_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_count  (key_count),
    .overflow   (overflow),
    .multi_key  (multi_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock edge; returns at the following falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic p, input logic [7:0] c);
    btn_pressed = p;
    btn_code    = c;
  endtask

  function automatic logic [7:0] code_of(input int row, input int col);
    logic [3:0] c;
    logic [3:0] r;
    c = 4'(1 << col);
    r = 4'(1 << row);
    return {c, r};
  endfunction

  // Press key (row,col) for hold edges, then release for 20 edges.
  task automatic press_release(input int row, input int col, input int hold, input bit expect_event);
    drive(1'b1, code_of(row, col));
    if (expect_event) exp_q.push_back(row * 4 + col);
    tick(hold);
    drive(1'b0, 8'h00);
    tick(20);
  endtask

  // Scoreboard/monitor: samples mid-low-phase, after the bench drives inputs.
  always @(negedge clk) begin
    #2;
    if (overflow)  ovf_cycles++;
    if (multi_key) multi_cycles++;
    if (key_valid && key_ready) begin
      pop_events++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got key_code=%0d, expected no event", key_code);
      end else begin
        check("pop_code", key_code, exp_q.pop_front());
      end
    end
  end

  initial begin
    int p0;
    int m0;
    int o0;

    vecs[0] = '{1'b1, 8'b0010_0100, 40, 1, 9,  0};
    vecs[1] = '{1'b1, 8'b1000_1000, 40, 1, 15, 0};
    vecs[2] = '{1'b1, 8'b0001_0001, 40, 1, 0,  0};
    vecs[3] = '{1'b1, 8'b0100_0010, 40, 1, 6,  0};
    vecs[4] = '{1'b1, 8'b0010_0011, 40, 0, 0,  1};
    vecs[5] = '{1'b1, 8'b0000_0000, 40, 0, 0,  1};
    vecs[6] = '{1'b1, 8'b1100_0001, 40, 0, 0,  1};
    vecs[7] = '{1'b0, 8'b0010_0100, 40, 0, 0,  0};
    vecs[8] = '{1'b1, 8'b0100_1000, 16, 0, 0,  0};
    vecs[9] = '{1'b1, 8'b0100_1000, 17, 1, 14, 0};

    reset       = 1'b0;
    key_ready   = 1'b0;
    drive(1'b0, 8'h00);
    #1;
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code",  key_code,  0);
    check("rst_key_count", key_count, 0);
    check("rst_overflow",  overflow,  0);
    check("rst_multi_key", multi_key, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(20);

    // Single press, consumer stalled: push lands exactly on edge 16.
    drive(1'b1, 8'b0010_0100);
    exp_q.push_back(9);
    tick(16);
    check("a_count_before_edge16", key_count, 0);
    tick(1);
    check("a_count_after_edge16", key_count, 1);
    check("a_key_valid", key_valid, 1);
    check("a_key_code", key_code, 9);
    tick(23);
    check("a_no_repeat", key_count, 1);
    drive(1'b0, 8'h00);
    tick(20);
    key_ready = 1'b1;
    tick(3);
    check("a_drained", key_count, 0);

    // Table of press/release vectors with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      p0 = pop_events;
      m0 = multi_cycles;
      drive(vecs[i].pressed, vecs[i].code);
      if (vecs[i].exp_events != 0) exp_q.push_back(vecs[i].exp_key);
      tick(vecs[i].hold);
      drive(1'b0, 8'h00);
      tick(20);
      check($sformatf("vec%0d_events", i), pop_events - p0, vecs[i].exp_events);
      check($sformatf("vec%0d_multi", i), multi_cycles - m0, vecs[i].exp_multi);
    end

    // Key changes without release, and chords from the locked state.
    p0 = pop_events;
    m0 = multi_cycles;
    drive(1'b1, code_of(2, 1)); exp_q.push_back(9);  tick(40);
    drive(1'b1, code_of(1, 2)); exp_q.push_back(6);  tick(40);
    drive(1'b1, 8'b0010_0011);                       tick(40);
    drive(1'b1, 8'b0110_0001);                       tick(40);
    drive(1'b1, code_of(3, 3)); exp_q.push_back(15); tick(40);
    drive(1'b0, 8'h00);                              tick(20);
    check("seq_events", pop_events - p0, 3);
    check("seq_multi", multi_cycles - m0, 1);

    // Bounce: pressed toggles every 5 cycles, never settling long enough.
    key_ready = 1'b0;
    m0 = multi_cycles;
    o0 = ovf_cycles;
    for (int i = 0; i < 12; i++) begin
      drive((i % 2) == 0, 8'b0010_0100);
      tick(5);
    end
    drive(1'b0, 8'h00);
    tick(40);
    check("bounce_count", key_count, 0);
    check("bounce_multi", multi_cycles - m0, 0);
    check("bounce_ovf", ovf_cycles - o0, 0);

    // Five presses into a four-deep FIFO: fifth dropped with one overflow pulse.
    o0 = ovf_cycles;
    press_release(0, 1, 20, 1'b1);
    press_release(0, 2, 20, 1'b1);
    press_release(1, 3, 20, 1'b1);
    press_release(2, 0, 20, 1'b1);
    press_release(3, 2, 20, 1'b0);
    check("ovf_count", key_count, 4);
    check("ovf_pulses", ovf_cycles - o0, 1);
    check("ovf_head", key_code, 1);
    key_ready = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick(1);
      check($sformatf("drain_count%0d", i), key_count, i);
    end
    key_ready = 1'b0;

    // Full FIFO with a pop on the very edge a new press qualifies.
    press_release(1, 3, 20, 1'b1);
    press_release(2, 0, 20, 1'b1);
    press_release(2, 2, 20, 1'b1);
    press_release(2, 3, 20, 1'b1);
    o0 = ovf_cycles;
    drive(1'b1, code_of(3, 0));
    exp_q.push_back(12);
    tick(16);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    check("fullpop_count", key_count, 4);
    check("fullpop_head", key_code, 8);
    drive(1'b0, 8'h00);
    tick(20);
    check("fullpop_ovf", ovf_cycles - o0, 0);
    key_ready = 1'b1;
    tick(6);
    check("fullpop_drained", key_count, 0);
    key_ready = 1'b0;

    // Reset pulse while col0,row0 is held: flush, then re-detect after debounce.
    drive(1'b1, code_of(0, 0));
    exp_q.push_back(0);
    tick(20);
    check("rh_count_before", key_count, 1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("rh_key_valid", key_valid, 0);
    check("rh_key_count", key_count, 0);
    check("rh_key_code", key_code, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(0);
    tick(16);
    check("rh_count_edge15", key_count, 0);
    tick(1);
    check("rh_count_edge16", key_count, 1);
    check("rh_valid_edge16", key_valid, 1);
    drive(1'b0, 8'h00);
    tick(20);
    key_ready = 1'b1;
    tick(3);
    check("rh_drained", key_count, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
